// File: rtl/cpu_core_ws_if.sv
// Instruction/data bus bundle for cpu_core_ws; master = core, slave = memories.
// Handshake: a request (instrReq/dataReq) stays high until the edge where its valid/ack is seen high; valid/ack are ignored while the request is low.
interface cpu_core_ws_if #(
    parameter int DATA_W  = 32,
    parameter int PC_W    = 12,
    parameter int DADDR_W = 14
);
    logic [PC_W-1:0]    instrAddr;
    logic               instrReq;
    logic [31:0]        instrIn;
    logic               instrValid;
    logic [DADDR_W-1:0] dataAddr;
    logic [DATA_W-1:0]  dataOut;
    logic               dataWrEn;
    logic               dataReq;
    logic [DATA_W-1:0]  dataIn;
    logic               dataAck;

    modport master (
        output instrAddr, instrReq,
        input  instrIn, instrValid,
        output dataAddr, dataOut, dataWrEn, dataReq,
        input  dataIn, dataAck
    );

    modport slave (
        input  instrAddr, instrReq,
        output instrIn, instrValid,
        input  dataAddr, dataOut, dataWrEn, dataReq,
        output dataIn, dataAck
    );
endinterface

// File: rtl/cpu_core_ws.sv
// Multi-cycle CPU core with wait-state instruction/data handshakes, carry/ADDC, HALT and sticky illegal flag.
// Optional unsigned multiplier (opcode 09) enabled by defining CPU_CORE_WS_MUL_EN.
module cpu_core_ws #(
    parameter int          DATA_W   = 32,
    parameter int          PC_W     = 12,
    parameter int          DADDR_W  = 14,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          nRst,
    cpu_core_ws_if.master bus,
    output logic [7:0]    cpuStatus
);
    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMWAIT   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [4:0] OP_LOAD  = 5'h01;
    localparam logic [4:0] OP_STORE = 5'h02;
    localparam logic [4:0] OP_AND   = 5'h03;
    localparam logic [4:0] OP_OR    = 5'h04;
    localparam logic [4:0] OP_XOR   = 5'h05;
    localparam logic [4:0] OP_ADD   = 5'h06;
    localparam logic [4:0] OP_ADDC  = 5'h07;
    localparam logic [4:0] OP_SUB   = 5'h08;
    localparam logic [4:0] OP_MUL   = 5'h09;
    localparam logic [4:0] OP_HALT  = 5'h1F;
    localparam logic [3:0] R_PC     = 4'hE;
    localparam logic [3:0] R_OVF    = 4'hF;

    state_t             r_state, w_next;
    logic [PC_W-1:0]    r_pc;
    logic [DATA_W-1:0]  r_regs [0:13];
    logic [DATA_W-1:0]  r_ovf;
    logic               r_zero, r_carry, r_ge, r_illegal;
    logic [31:0]        r_ir;
    logic [DATA_W-1:0]  r_a, r_b, r_result;
    logic               r_carry_n, r_ge_n, r_pass, r_legal;
    logic [DADDR_W-1:0] r_daddr;
    logic [DATA_W-1:0]  r_dout;
    logic               r_wren;

    logic               w_imb, w_cmp;
    logic [3:0]         w_ra, w_rb, w_rc;
    logic [13:0]        w_imm;
    logic [4:0]         w_opc;
    logic [2:0]         w_cond;
    logic [DATA_W-1:0]  w_imm_sx, w_aval, w_bval, w_bop, w_result;
    logic [DATA_W:0]    w_sum;
    logic               w_cin, w_carry_n, w_ge_n, w_pass, w_legal, w_is_mem;
    logic [PC_W-1:0]    w_pc_inc;

`ifdef CPU_CORE_WS_MUL_EN
    logic [DATA_W-1:0]   r_hi;
    logic [2*DATA_W-1:0] w_prod;
    assign w_prod = {{DATA_W{1'b0}}, r_a} * {{DATA_W{1'b0}}, r_b};
`endif

    assign w_imb    = r_ir[31];
    assign w_ra     = r_ir[30:27];
    assign w_rb     = r_ir[26:23];
    assign w_imm    = r_ir[26:13];
    assign w_opc    = r_ir[12:8];
    assign w_rc     = r_ir[7:4];
    assign w_cond   = r_ir[3:1];
    assign w_cmp    = r_ir[0];
    assign w_imm_sx = {{(DATA_W-14){w_imm[13]}}, w_imm};
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_aval = '0;
        if (w_ra == R_PC)
            w_aval = DATA_W'(r_pc);
        else if (w_ra == R_OVF)
            w_aval = r_ovf;
        else
            w_aval = r_regs[w_ra];
    end

    assign w_bval = w_imb ? w_imm_sx : ((w_rb < R_PC) ? r_regs[w_rb] : '0);

    // One adder serves ADD/ADDC/SUB and the LOAD effective address (SUB as A + ~B + 1).
    assign w_bop  = (w_opc == OP_SUB) ? ~r_b : r_b;
    assign w_cin  = (w_opc == OP_SUB) | ((w_opc == OP_ADDC) & r_carry);
    assign w_sum  = {1'b0, r_a} + {1'b0, w_bop} + {{DATA_W{1'b0}}, w_cin};
    assign w_ge_n = $signed(r_a) >= $signed(r_b);

    always_comb begin
        w_legal   = 1'b1;
        w_is_mem  = 1'b0;
        w_result  = '0;
        w_carry_n = 1'b0;
        case (w_opc)
            OP_LOAD:  begin w_is_mem = 1'b1; w_result = w_sum[DATA_W-1:0]; end
            OP_STORE: begin w_is_mem = 1'b1; w_result = r_a; end
            OP_AND:   w_result = r_a & r_b;
            OP_OR:    w_result = r_a | r_b;
            OP_XOR:   w_result = r_a ^ r_b;
            OP_ADD, OP_ADDC, OP_SUB: begin
                w_result  = w_sum[DATA_W-1:0];
                w_carry_n = w_sum[DATA_W];
            end
`ifdef CPU_CORE_WS_MUL_EN
            OP_MUL:   w_result = w_prod[DATA_W-1:0];
`endif
            OP_HALT:  w_result = '0;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_pass = 1'b1;
        case (w_cond)
            3'd1:    w_pass = 1'b0;
            3'd2:    w_pass = r_zero;
            3'd3:    w_pass = ~r_zero;
            3'd4:    w_pass = r_ge;
            3'd5:    w_pass = ~r_ge;
            default: w_pass = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (bus.instrValid) w_next = S_DECODE;
            S_DECODE:    w_next = S_EXECUTE;
            S_EXECUTE:   w_next = (w_is_mem && w_pass) ? S_MEMWAIT : S_WRITEBACK;
            S_MEMWAIT:   if (bus.dataAck) w_next = S_WRITEBACK;
            S_WRITEBACK: w_next = (r_legal && r_pass && w_opc == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_pc      <= PC_W'(RESET_PC);
            for (int i = 0; i < 14; i++) r_regs[i] <= '0;
            r_ovf     <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ge      <= 1'b0;
            r_illegal <= 1'b0;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_carry_n <= 1'b0;
            r_ge_n    <= 1'b0;
            r_pass    <= 1'b0;
            r_legal   <= 1'b0;
            r_daddr   <= '0;
            r_dout    <= '0;
            r_wren    <= 1'b0;
`ifdef CPU_CORE_WS_MUL_EN
            r_hi      <= '0;
`endif
        end else begin
            case (r_state)
                S_FETCH: if (bus.instrValid) r_ir <= bus.instrIn;
                S_DECODE: begin
                    r_a <= w_aval;
                    r_b <= w_bval;
                end
                S_EXECUTE: begin
                    r_result  <= w_result;
                    r_carry_n <= w_carry_n;
                    r_ge_n    <= w_ge_n;
                    r_pass    <= w_pass;
                    r_legal   <= w_legal;
`ifdef CPU_CORE_WS_MUL_EN
                    r_hi      <= w_prod[2*DATA_W-1:DATA_W];
`endif
                    if (w_is_mem && w_pass) begin
                        r_daddr <= (w_opc == OP_LOAD) ? w_sum[DADDR_W-1:0] : r_b[DADDR_W-1:0];
                        if (w_opc == OP_STORE) r_dout <= r_a;
                        r_wren  <= (w_opc == OP_STORE);
                    end
                end
                S_MEMWAIT: if (bus.dataAck) begin
                    r_wren <= 1'b0;
                    if (!r_wren) r_result <= bus.dataIn;
                end
                S_WRITEBACK: begin
                    if (w_cmp && r_legal) begin
                        r_zero  <= (r_result == '0);
                        r_carry <= r_carry_n;
                        r_ge    <= r_ge_n;
                    end
                    if (!r_legal) begin
                        r_illegal <= 1'b1;
                        r_pc      <= w_pc_inc;
                    end else if (!r_pass || w_opc == OP_STORE) begin
                        r_pc <= w_pc_inc;
                    end else if (w_opc != OP_HALT) begin
                        if (w_rc == R_PC) begin
                            r_pc <= r_result[PC_W-1:0];
                        end else if (w_rc == R_OVF) begin
                            r_ovf <= r_result;
                            r_pc  <= w_pc_inc;
                        end else begin
                            r_regs[w_rc] <= r_result;
                            r_pc         <= w_pc_inc;
                        end
`ifdef CPU_CORE_WS_MUL_EN
                        if (w_opc == OP_MUL && w_rc != R_OVF) r_ovf <= r_hi;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // instrReq is gated by nRst so it drops the moment reset asserts.
    assign bus.instrAddr = r_pc;
    assign bus.instrReq  = (r_state == S_FETCH) && nRst;
    assign bus.dataReq   = (r_state == S_MEMWAIT);
    assign bus.dataAddr  = r_daddr;
    assign bus.dataOut   = r_dout;
    assign bus.dataWrEn  = r_wren;
    assign cpuStatus     = {r_ge, r_carry, r_zero, r_illegal, (r_state == S_HALT), 3'(r_state)};
endmodule

// File: tb/tb_cpu_core_ws.sv
// Directed bench for cpu_core_ws: instruction feeder tasks, a data-memory responder with programmable ack delay.
module tb_cpu_core_ws;
    localparam int DW = 32;
    localparam int PW = 12;
    localparam int AW = 14;
    localparam logic [4:0] OP_LOAD  = 5'h01;
    localparam logic [4:0] OP_STORE = 5'h02;
    localparam logic [4:0] OP_ADD   = 5'h06;
    localparam logic [4:0] OP_ADDC  = 5'h07;
    localparam logic [4:0] OP_SUB   = 5'h08;
    localparam logic [4:0] OP_MUL   = 5'h09;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic [7:0] cpuStatus;
    int         checks = 0;
    int         failures = 0;

    cpu_core_ws_if #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW)) bus();

    cpu_core_ws #(.DATA_W(DW), .PC_W(PW), .DADDR_W(AW), .RESET_PC(32'h010)) dut (
        .clk       (clk),
        .nRst      (nRst),
        .bus       (bus),
        .cpuStatus (cpuStatus)
    );

    always #5 clk = ~clk;

    int            ack_delay = 0;
    int            req_cnt = 0;
    int            req_total = 0;
    int            stable_err = 0;
    logic [AW-1:0] first_addr;
    logic [DW-1:0] first_dout;
    logic          first_wren;
    logic [DW-1:0] dmem [0:1023];
    logic [AW-1:0] st_addr_q[$];
    logic [DW-1:0] st_data_q[$];
    int            len_q[$];

    // Data memory responder: acks after ack_delay request cycles, logs writes and request lengths.
    initial begin
        bus.dataAck = 1'b0;
        bus.dataIn  = '0;
        for (int i = 0; i < 1024; i++) dmem[i] = '0;
        forever begin
            @(negedge clk);
            if (bus.dataReq) begin
                if (req_cnt == 0) begin
                    first_addr = bus.dataAddr;
                    first_dout = bus.dataOut;
                    first_wren = bus.dataWrEn;
                end else if (bus.dataAddr !== first_addr || bus.dataOut !== first_dout ||
                             bus.dataWrEn !== first_wren) begin
                    stable_err++;
                end
                req_cnt++;
                req_total++;
                bus.dataAck = (req_cnt > ack_delay);
                bus.dataIn  = dmem[bus.dataAddr[9:0]];
                if (bus.dataAck && bus.dataWrEn) begin
                    dmem[bus.dataAddr[9:0]] = bus.dataOut;
                    st_addr_q.push_back(bus.dataAddr);
                    st_data_q.push_back(bus.dataOut);
                end
            end else begin
                bus.dataAck = 1'b0;
                if (req_cnt != 0) len_q.push_back(req_cnt);
                req_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ei(input logic [3:0] ra, input logic [13:0] imm, input logic [4:0] opc,
                                       input logic [3:0] rc, input logic [2:0] cond, input logic cmp);
        return {1'b1, ra, imm, opc, rc, cond, cmp};
    endfunction

    function automatic logic [31:0] er(input logic [3:0] ra, input logic [3:0] rb, input logic [4:0] opc,
                                       input logic [3:0] rc, input logic [2:0] cond, input logic cmp);
        return {1'b0, ra, rb, 10'd0, opc, rc, cond, cmp};
    endfunction

    // Feeds one instruction after fwait stall cycles; cyc counts cycles until the next fetch (or halt).
    task automatic run_instr(input logic [31:0] ins, input int fwait, output int cyc);
        int n;
        cyc = 0;
        n = 0;
        while (!bus.instrReq && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (!bus.instrReq) begin
            failures++;
            $display("FAIL fetch_timeout: instrReq=%b want 1 within 100 cycles", bus.instrReq);
            return;
        end
        repeat (fwait) begin bus.instrValid = 1'b0; @(negedge clk); cyc++; end
        bus.instrIn    = ins;
        bus.instrValid = 1'b1;
        @(negedge clk);
        cyc++;
        bus.instrValid = 1'b0;
        n = 0;
        while (!bus.instrReq && !cpuStatus[3] && n < 100) begin @(negedge clk); cyc++; n++; end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL exec_timeout: cycles=%0d want completion under 100", cyc);
        end
    endtask

    task automatic store_reg(input logic [3:0] ra, input logic [13:0] addr, output logic [DW-1:0] data, output int cyc);
        int n0 = st_data_q.size();
        run_instr(ei(ra, addr, OP_STORE, 4'h0, 3'd0, 1'b0), 0, cyc);
        if (st_data_q.size() > n0) begin
            data = st_data_q.pop_front();
            void'(st_addr_q.pop_front());
        end else begin
            data = 'x;
        end
    endtask

    task automatic test_reset();
        bus.instrValid = 1'b0;
        bus.instrIn    = '0;
        nRst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.instrAddr !== 12'h010) begin
            failures++; $display("FAIL reset_instrAddr: got %h want 010", bus.instrAddr);
        end
        checks++;
        if ({bus.instrReq, bus.dataReq, bus.dataWrEn} !== 3'b000) begin
            failures++; $display("FAIL reset_reqs: got %b want 000", {bus.instrReq, bus.dataReq, bus.dataWrEn});
        end
        checks++;
        if (cpuStatus !== 8'h00) begin
            failures++; $display("FAIL reset_status: got %h want 00", cpuStatus);
        end
        nRst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.instrReq, cpuStatus[2:0], bus.instrAddr} !== {1'b1, 3'd0, 12'h010}) begin
                failures++;
                $display("FAIL reset_fetch_hold: req=%b state=%0d addr=%h want 1 0 010",
                         bus.instrReq, cpuStatus[2:0], bus.instrAddr);
            end
        end
    endtask

    task automatic test_alu_flags();
        int cyc;
        logic [DW-1:0] d;
        run_instr(ei(4'd0, 14'h3FFF, OP_ADD, 4'd1, 3'd0, 1'b1), 0, cyc);
        checks++;
        if (cyc !== 4) begin failures++; $display("FAIL add_cycles: got %0d want 4", cyc); end
        checks++;
        if (cpuStatus[7:5] !== 3'b100) begin
            failures++; $display("FAIL add_flags: got ge,c,z=%b want 100", cpuStatus[7:5]);
        end
        checks++;
        if (bus.instrAddr !== 12'h011) begin
            failures++; $display("FAIL add_pc: got %h want 011", bus.instrAddr);
        end
        run_instr(ei(4'd1, 14'h0001, OP_ADDC, 4'd2, 3'd0, 1'b1), 0, cyc);
        checks++;
        if (cpuStatus[7:5] !== 3'b011) begin
            failures++; $display("FAIL addc_flags: got ge,c,z=%b want 011", cpuStatus[7:5]);
        end
        store_reg(4'd2, 14'h24, d, cyc);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL addc_r2: got %h want 00000000", d); end
        checks++;
        if (cyc !== 5) begin failures++; $display("FAIL store_cycles: got %0d want 5", cyc); end
    endtask

    task automatic test_store_wait();
        int cyc;
        int s0 = stable_err;
        ack_delay = 2;
        run_instr(ei(4'd1, 14'h20, OP_STORE, 4'd0, 3'd0, 1'b0), 0, cyc);
        ack_delay = 0;
        checks++;
        if (cyc !== 7) begin failures++; $display("FAIL store_wait_cycles: got %0d want 7", cyc); end
        checks++;
        if (len_q.size() == 0 || len_q[len_q.size()-1] !== 3) begin
            failures++; $display("FAIL store_req_len: got %0d want 3", (len_q.size() == 0) ? -1 : len_q[len_q.size()-1]);
        end
        checks++;
        if (first_wren !== 1'b1 || stable_err !== s0) begin
            failures++; $display("FAIL store_stable: wren=%b stable_err=%0d want 1 %0d", first_wren, stable_err, s0);
        end
        checks++;
        if (st_addr_q.size() == 0 || st_addr_q[0] !== 14'h20 || st_data_q[0] !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL store_addr_data: got %h/%h want 0020/ffffffff",
                     (st_addr_q.size() == 0) ? 14'h0 : st_addr_q[0], (st_data_q.size() == 0) ? 32'h0 : st_data_q[0]);
        end
        if (st_addr_q.size() != 0) begin void'(st_addr_q.pop_front()); void'(st_data_q.pop_front()); end
    endtask

    task automatic test_load();
        int cyc;
        logic [DW-1:0] d;
        run_instr(ei(4'd0, 14'h20, OP_LOAD, 4'd3, 3'd0, 1'b0), 0, cyc);
        checks++;
        if (cyc !== 5) begin failures++; $display("FAIL load_cycles: got %0d want 5", cyc); end
        store_reg(4'd3, 14'h28, d, cyc);
        checks++;
        if (d !== 32'hFFFFFFFF) begin failures++; $display("FAIL load_r3: got %h want ffffffff", d); end
    endtask

    task automatic test_cond_store();
        int cyc;
        int r0;
        logic [PW-1:0] pc0;
        logic [DW-1:0] d;
        run_instr(ei(4'd0, 14'h0003, OP_ADD, 4'd5, 3'd0, 1'b1), 2, cyc);
        checks++;
        if (cyc !== 6 || cpuStatus[7:5] !== 3'b000) begin
            failures++; $display("FAIL add3_wait_flags: cycles=%0d flags=%b want 6 000", cyc, cpuStatus[7:5]);
        end
        r0  = req_total;
        pc0 = bus.instrAddr;
        run_instr(ei(4'd1, 14'h30, OP_STORE, 4'd0, 3'd2, 1'b0), 0, cyc);
        checks++;
        if (cyc !== 4 || req_total !== r0) begin
            failures++; $display("FAIL cond_store_skip: cycles=%0d req_cycles=%0d want 4 0", cyc, req_total - r0);
        end
        checks++;
        if (bus.instrAddr !== pc0 + 12'd1) begin
            failures++; $display("FAIL cond_store_pc: got %h want %h", bus.instrAddr, pc0 + 12'd1);
        end
        run_instr(ei(4'd0, 14'h0007, OP_ADD, 4'd5, 3'd1, 1'b0), 0, cyc);
        store_reg(4'd5, 14'h2C, d, cyc);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL cond_never: got %h want 00000003", d); end
        run_instr(ei(4'd1, 14'h34, OP_STORE, 4'd0, 3'd3, 1'b0), 0, cyc);
        checks++;
        if (cyc !== 5 || st_data_q.size() == 0 || st_data_q[0] !== 32'hFFFFFFFF) begin
            failures++; $display("FAIL cond_notzero_store: cycles=%0d logged=%0d want 5 1", cyc, st_data_q.size());
        end
        while (st_data_q.size() != 0) begin void'(st_data_q.pop_front()); void'(st_addr_q.pop_front()); end
    endtask

    task automatic test_sub();
        int cyc;
        logic [DW-1:0] d;
        run_instr(ei(4'd0, 14'h0005, OP_ADD, 4'd6, 3'd0, 1'b0), 0, cyc);
        run_instr(ei(4'd0, 14'h0007, OP_ADD, 4'd7, 3'd0, 1'b0), 0, cyc);
        run_instr(er(4'd7, 4'd6, OP_SUB, 4'd8, 3'd0, 1'b1), 0, cyc);
        checks++;
        if (cpuStatus[7:5] !== 3'b110) begin
            failures++; $display("FAIL sub_7_5_flags: got ge,c,z=%b want 110", cpuStatus[7:5]);
        end
        run_instr(ei(4'd0, 14'h0000, OP_ADDC, 4'd10, 3'd0, 1'b0), 0, cyc);
        run_instr(er(4'd6, 4'd7, OP_SUB, 4'd9, 3'd0, 1'b1), 0, cyc);
        checks++;
        if (cpuStatus[7:5] !== 3'b000) begin
            failures++; $display("FAIL sub_5_7_flags: got ge,c,z=%b want 000", cpuStatus[7:5]);
        end
        store_reg(4'd9, 14'h40, d, cyc);
        checks++;
        if (d !== 32'hFFFFFFFE) begin failures++; $display("FAIL sub_5_7_result: got %h want fffffffe", d); end
        store_reg(4'd8, 14'h41, d, cyc);
        checks++;
        if (d !== 32'd2) begin failures++; $display("FAIL sub_7_5_result: got %h want 00000002", d); end
        store_reg(4'd10, 14'h42, d, cyc);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL addc_carry_in: got %h want 00000001", d); end
    endtask

    task automatic test_mul_illegal();
        int cyc;
        logic [DW-1:0] d;
        run_instr(ei(4'd1, 14'h0002, OP_MUL, 4'd4, 3'd0, 1'b0), 0, cyc);
        checks++;
        if (cyc !== 4) begin failures++; $display("FAIL mul_cycles: got %0d want 4", cyc); end
`ifdef CPU_CORE_WS_MUL_EN
        checks++;
        if (cpuStatus[4] !== 1'b0) begin failures++; $display("FAIL mul_illegal_bit: got %b want 0", cpuStatus[4]); end
        store_reg(4'd4, 14'h50, d, cyc);
        checks++;
        if (d !== 32'hFFFFFFFE) begin failures++; $display("FAIL mul_low: got %h want fffffffe", d); end
        store_reg(4'hF, 14'h51, d, cyc);
        checks++;
        if (d !== 32'd1) begin failures++; $display("FAIL mul_high: got %h want 00000001", d); end
`else
        checks++;
        if (cpuStatus[4] !== 1'b1) begin failures++; $display("FAIL mul_illegal_bit: got %b want 1", cpuStatus[4]); end
        store_reg(4'd4, 14'h50, d, cyc);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL mul_r4_unchanged: got %h want 00000000", d); end
        store_reg(4'hF, 14'h51, d, cyc);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL mul_ovf_unchanged: got %h want 00000000", d); end
`endif
        run_instr(ei(4'd0, 14'h0001, 5'h0A, 4'd5, 3'd0, 1'b1), 0, cyc);
        checks++;
        if (cpuStatus[4] !== 1'b1) begin failures++; $display("FAIL illegal_0a: got %b want 1", cpuStatus[4]); end
        store_reg(4'd5, 14'h52, d, cyc);
        checks++;
        if (d !== 32'd3) begin failures++; $display("FAIL illegal_no_write: got %h want 00000003", d); end
    endtask

    task automatic test_pc_write();
        int cyc;
        logic [DW-1:0] d;
        run_instr(ei(4'd0, 14'h07FF, OP_ADD, 4'hE, 3'd0, 1'b0), 0, cyc);
        checks++;
        if (bus.instrAddr !== 12'h7FF || cyc !== 4) begin
            failures++; $display("FAIL pc_write: addr=%h cycles=%0d want 7ff 4", bus.instrAddr, cyc);
        end
        run_instr(ei(4'hE, 14'h0000, OP_ADD, 4'd11, 3'd0, 1'b0), 0, cyc);
        store_reg(4'd11, 14'h60, d, cyc);
        checks++;
        if (d !== 32'h7FF) begin failures++; $display("FAIL pc_read_ra_e: got %h want 000007ff", d); end
    endtask

    task automatic test_halt();
        int cyc;
        int req_seen = 0;
        logic [PW-1:0] pc0 = bus.instrAddr;
        run_instr(ei(4'd0, 14'h0000, OP_HALT, 4'd0, 3'd1, 1'b0), 0, cyc);
        checks++;
        if (cpuStatus[3] !== 1'b0 || bus.instrAddr !== pc0 + 12'd1) begin
            failures++; $display("FAIL halt_cond_fail: halted=%b addr=%h want 0 %h", cpuStatus[3], bus.instrAddr, pc0 + 12'd1);
        end
        run_instr(ei(4'd0, 14'h0000, OP_HALT, 4'd0, 3'd0, 1'b0), 0, cyc);
        checks++;
        if (cpuStatus[3] !== 1'b1 || cpuStatus[2:0] !== 3'd5 || cyc !== 4) begin
            failures++; $display("FAIL halt_enter: halted=%b state=%0d cycles=%0d want 1 5 4", cpuStatus[3], cpuStatus[2:0], cyc);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.instrReq || bus.dataReq) req_seen++;
        end
        checks++;
        if (req_seen !== 0 || bus.instrAddr !== pc0 + 12'd1) begin
            failures++; $display("FAIL halt_frozen: req_cycles=%0d addr=%h want 0 %h", req_seen, bus.instrAddr, pc0 + 12'd1);
        end
    endtask

    task automatic test_reset_memwait();
        int n = 0;
        int cyc;
        logic [DW-1:0] d;
        nRst = 1'b0;
        @(negedge clk);
        nRst = 1'b1;
        ack_delay = 20;
        bus.instrIn    = ei(4'd1, 14'h70, OP_STORE, 4'd0, 3'd0, 1'b0);
        bus.instrValid = 1'b1;
        @(negedge clk);
        bus.instrValid = 1'b0;
        while (!bus.dataReq && n < 10) begin @(negedge clk); n++; end
        checks++;
        if (bus.dataReq !== 1'b1) begin failures++; $display("FAIL rst_mw_enter: dataReq=%b want 1", bus.dataReq); end
        @(negedge clk);
        #2;
        nRst = 1'b0;
        #1;
        checks++;
        if ({bus.dataReq, bus.dataWrEn, bus.instrReq} !== 3'b000 || cpuStatus !== 8'h00 || bus.instrAddr !== 12'h010) begin
            failures++;
            $display("FAIL rst_mw_async: req/wr/ireq=%b status=%h addr=%h want 000 00 010",
                     {bus.dataReq, bus.dataWrEn, bus.instrReq}, cpuStatus, bus.instrAddr);
        end
        @(negedge clk);
        nRst = 1'b1;
        ack_delay = 0;
        store_reg(4'd1, 14'h74, d, cyc);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL rst_regs_cleared: got %h want 00000000", d); end
    endtask

    initial begin
        test_reset();
        test_alu_flags();
        test_store_wait();
        test_load();
        test_cond_store();
        test_sub();
        test_mul_illegal();
        test_pc_write();
        test_halt();
        test_reset_memwait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cpu_core_ws.md
Name: cpu_core_ws

Overview:
- Parametrised multi-cycle successor to the team's 32-bit four-state CPU core.
- Width, PC and data-address sizes are generics.
- Instruction and data memories have valid/ack wait-state handshakes.
- Adds conditional LOAD/STORE, a carry flag with ADDC, a HALT opcode and a sticky illegal-opcode flag.
- Sits between instruction ROM and data RAM/bus fabric, same place as the existing core.

Parameters:
DATA_W, 32, datapath/register width (>=16)
PC_W, 12, program counter and instruction address width (<=DATA_W)
DADDR_W, 14, data address width (<=DATA_W)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock, all state on rising edge
nRst  in  1  asynchronous active-low reset
instrAddr  out  PC_W  instruction address, equals pc
instrReq  out  1  fetch request, high throughout FETCH
instrIn  in  32  instruction word
instrValid  in  1  instrIn valid; sampled only while instrReq
dataAddr  out  DADDR_W  data address
dataOut  out  DATA_W  store data
dataWrEn  out  1  1=write, 0=read; qualified by dataReq
dataReq  out  1  data access request, high throughout MEMWAIT
dataIn  in  DATA_W  load data, captured on the edge where dataAck=1
dataAck  in  1  access complete; ignored while dataReq=0
cpuStatus  out  8  [2:0] state, [3] halted, [4] illegal (sticky), [5] zero, [6] carry, [7] ge

Behaviour:
- Reset (async, nRst=0):
  - pc=RESET_PC; r0..r13, overflow and flags = 0; illegal=0; state=FETCH.
  - All outputs 0 except instrAddr=RESET_PC. instrReq/dataReq drop immediately, including mid-access.
- Instruction fields (unchanged):
  - Imb[31], Ra[30:27], Rb[26:23], Imm[26:13], Opc[12:8], Rc[7:4], Cond[3:1], Cmp[0].
  - Imm is sign-extended to DATA_W.
- Opcodes:
  - 01 LOAD, 02 STORE, 03 AND, 04 OR, 05 XOR, 06 ADD, 07 ADDC, 08 SUB, 09 MUL (optional), 1F HALT.
  - All others are illegal.
- State codes: FETCH=0, DECODE=1, EXECUTE=2, MEMWAIT=3, WRITEBACK=4, HALT=5.
- FETCH:
  - instrReq=1, instrAddr=pc.
  - On an edge with instrValid=1, latch fields and go to DECODE; otherwise stay.
- DECODE:
  - Aval: r[Ra]; Ra=E gives pc zero-extended; Ra=F gives overflow.
  - Bval: Imb ? Imm : (Rb<E ? r[Rb] : 0).
- EXECUTE:
  - Compute result, next flags and condition pass.
  - LOAD/STORE with condition pass: drive dataAddr (LOAD: (Aval+Bval)[DADDR_W-1:0]; STORE: Bval[DADDR_W-1:0]), dataOut=Aval on STORE, dataWrEn=(Opc==STORE), then go to MEMWAIT.
  - Everything else goes to WRITEBACK.
- MEMWAIT:
  - dataReq=1; dataAddr, dataOut and dataWrEn are held stable.
  - On the dataAck edge: capture dataIn (LOAD), drop dataReq and dataWrEn, go to WRITEBACK.
- WRITEBACK:
  - Cmp=1 updates flags regardless of condition.
  - On condition pass, result (or the loaded word) goes to Rc. Rc=E writes pc=value[PC_W-1:0] with no increment; Rc=F writes overflow, then pc+1; otherwise r[Rc] is written, then pc+1.
  - On condition fail: pc+1 only, no register or memory effect.
  - Next state is FETCH.
- Conditions:
  - 0 always, 1 never, 2 zero, 3 !zero, 4 ge, 5 !ge; codes 6 and 7 mean always.
  - Conditions use the flags held before this instruction.
- Flags (computed every instruction, committed only when Cmp=1):
  - zero = (result==0).
  - carry = carry-out of ADD/ADDC, or of A+~B+1 for SUB; 0 for other ops.
  - ge = signed(Aval) >= signed(Bval).
  - For LOAD, result = loaded word.
- ADDC = A+B+carry. PC arithmetic wraps mod 2^PC_W.
- Cycle counts:
  - ALU op, or LOAD/STORE with condition fail: 4 cycles with zero wait states.
  - LOAD/STORE with condition pass: 5 cycles plus ack delay.
  - Each FETCH wait cycle adds one cycle.
- HALT:
  - Condition pass: enter HALT. instrReq=dataReq=0, cpuStatus[3]=1, pc frozen; exit only by reset.
  - Condition fail: pc+1.
- Illegal opcode: behaves as a no-write instruction (pc+1), sets cpuStatus[4] until reset.

Optional Feature:
- Macro CPU_CORE_WS_MUL_EN.
- Defined: MUL forms the 2*DATA_W-bit unsigned product; low half goes to Rc, high half to overflow (written even when Rc≠F; Rc=F takes the low half); completes in WRITEBACK with no extra cycles; zero flag from the low half.
- Undefined: opcode 09 is illegal (sets cpuStatus[4], pc+1, no writes).

Test Plan:
- Reset with RESET_PC=0x010, instrValid held 0 for 3 cycles -> instrAddr=0x010, instrReq=1, cpuStatus[2:0]=0, no state advance until instrValid=1.
- ADD r1=r0+Imm(-1) with Cmp=1 -> r1=0xFFFFFFFF, zero=0, carry=0, ge=1 (0 >= -1); ADDC r2=r1+Imm1 with Cmp=1 -> r2=0, carry=1, zero=1.
- STORE r1 to addr Imm 0x20 with dataAck delayed 2 cycles -> dataReq high for exactly 3 cycles, dataWrEn=1, dataAddr=0x20, dataOut=0xFFFFFFFF stable; LOAD r3 from r0+0x20 with ack=1 -> r3=0xFFFFFFFF, 5 cycles total.
- STORE with Cond=zero and zero=0 -> dataReq never asserted, pc+1, 4 cycles.
- Write Rc=E with Imm 0x7FF, PC_W=12 -> next instrAddr=0x7FF; SUB 5-7 with Cmp -> ge=0, result 0xFFFFFFFE; opcode 1F -> halted=1, instrReq stays 0 for 10 cycles.
- With CPU_CORE_WS_MUL_EN, MUL 0xFFFFFFFF*2 into r4 -> r4=0xFFFFFFFE, overflow=1; without the macro -> r4 unchanged, cpuStatus[4]=1; nRst pulsed low mid-MEMWAIT -> dataReq falls asynchronously.
